instr_register_exec: RTL

Parametrised next-generation instruction register: stores up to DEPTH instructions (opcode plus two signed operands), computes each instruction's result in a two-stage write pipeline and holds it with the entry. Adds an auto-increment write mode, per-entry valid and divide-error tracking, occupancy count, and same-cycle read-after-write forwarding. It sits where the DUT sits in the lab top level, driven through the team's testbench interface; the interface adds the new signals.

---
 rtl/instr_register_pkg.sv | 30 +++
 rtl/instr_exec_alu.sv | 44 ++++
 rtl/instr_register_exec.sv | 109 ++++++++++
 3 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register: opcodes, operand/result widths
// and the stored instruction record.
package instr_register_pkg;

  localparam int DEFAULT_DEPTH     = 32;
  localparam int DEFAULT_OPERAND_W = 32;

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  typedef logic signed [DEFAULT_OPERAND_W-1:0]   operand_t;
  typedef logic signed [2*DEFAULT_OPERAND_W-1:0] result_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  result;
    logic     div_err;
  } instruction_t;

endpackage

// File: rtl/instr_exec_alu.sv
// Combinational execute unit: full-width signed result per opcode, with a
// divide-by-zero flag for DIV/MOD.
module instr_exec_alu
  import instr_register_pkg::*;
#(
  parameter int OPERAND_W = DEFAULT_OPERAND_W
) (
  input  opcode_t                       opc,
  input  logic signed [OPERAND_W-1:0]   a,
  input  logic signed [OPERAND_W-1:0]   b,
  output logic signed [2*OPERAND_W-1:0] result,
  output logic                          div_err
);

  // Widening first keeps MULT exact and lets MIN/-1 divide without overflow.
  logic signed [2*OPERAND_W-1:0] ax;
  logic signed [2*OPERAND_W-1:0] bx;

  assign ax = a;
  assign bx = b;

  always_comb begin
    result  = '0;
    div_err = 1'b0;
    unique case (opc)
      ZERO:  result = '0;
      PASSA: result = ax;
      PASSB: result = bx;
      ADD:   result = ax + bx;
      SUB:   result = ax - bx;
      MULT:  result = ax * bx;
      DIV: begin
        if (b == '0) div_err = 1'b1;
        else         result  = ax / bx;
      end
      MOD: begin
        if (b == '0) div_err = 1'b1;
        else         result  = ax % bx;
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/instr_register_exec.sv
// Instruction register with a two-stage capture/execute write pipeline,
// per-entry valid tracking, occupancy count and read-after-write forwarding.
module instr_register_exec
  import instr_register_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int OPERAND_W = DEFAULT_OPERAND_W
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         load_en,
  input  logic                         auto_inc,
  input  opcode_t                      opcode,
  input  logic signed [OPERAND_W-1:0]  operand_a,
  input  logic signed [OPERAND_W-1:0]  operand_b,
  input  logic [$clog2(DEPTH)-1:0]     write_pointer,
  input  logic [$clog2(DEPTH)-1:0]     read_pointer,
  output instruction_t                 instruction_word,
  output logic                         rd_valid,
  output logic [$clog2(DEPTH)-1:0]     wr_ptr,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full
);

  localparam int AW = $clog2(DEPTH);

  logic                          vld_p1;
  opcode_t                       opc_p1;
  logic signed [OPERAND_W-1:0]   a_p1;
  logic signed [OPERAND_W-1:0]   b_p1;
  logic [AW-1:0]                 addr_p1;

  logic signed [2*OPERAND_W-1:0] result_p2;
  logic                          div_err_p2;
  instruction_t                  entry_p2;

  instruction_t                  mem [DEPTH];
  logic [DEPTH-1:0]              valid;

  // Stage 1: capture the request; wr_ptr advances on the capture edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1 <= 1'b0;
      wr_ptr <= '0;
    end else begin
      vld_p1 <= load_en;
      if (load_en && auto_inc) wr_ptr <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (load_en) begin
      opc_p1  <= opcode;
      a_p1    <= operand_a;
      b_p1    <= operand_b;
      addr_p1 <= auto_inc ? wr_ptr : write_pointer;
    end
  end

  // Stage 2: execute from the stage-1 register and commit the entry.
  instr_exec_alu #(.OPERAND_W(OPERAND_W)) u_alu (
    .opc     (opc_p1),
    .a       (a_p1),
    .b       (b_p1),
    .result  (result_p2),
    .div_err (div_err_p2)
  );

  always_comb begin
    entry_p2         = '0;
    entry_p2.opc     = opc_p1;
    entry_p2.op_a    = a_p1;
    entry_p2.op_b    = b_p1;
    entry_p2.result  = result_p2;
    entry_p2.div_err = div_err_p2;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      valid <= '0;
      count <= '0;
    end else if (vld_p1) begin
      mem[addr_p1]   <= entry_p2;
      valid[addr_p1] <= 1'b1;
      if (!valid[addr_p1]) count <= count + 1'b1;
    end
  end

  assign full = (count == (AW+1)'(DEPTH));

  // Read port; a same-edge commit to the read address is forwarded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instruction_word <= '0;
      rd_valid         <= 1'b0;
    end else if (vld_p1 && (addr_p1 == read_pointer)) begin
      instruction_word <= entry_p2;
      rd_valid         <= 1'b1;
    end else if (valid[read_pointer]) begin
      instruction_word <= mem[read_pointer];
      rd_valid         <= 1'b1;
    end else begin
      instruction_word <= '0;
      rd_valid         <= 1'b0;
    end
  end

endmodule
